tt_um_accelshark_psg_writer: RTL and testbench

TT_UM_ACCELSHARK_PSG_WRITER -- requirements
Module: tt_um_accelshark_psg_writer

---
 rtl/tt_um_accelshark_psg_writer.sv | 197 +++++++++++++++++++
 tb/tb_tt_um_accelshark_psg_writer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_accelshark_psg_writer.sv
// Nybble-serial register writer for a PSG control port.
// One host byte write becomes a strobe sequence: an optional address nybble,
// the low data nybble, the high data nybble, then a repeated high-nybble strobe
// that makes the receiver commit the assembled byte. Every strobe is followed
// by GAP_CYCLES idle cycles.
module tt_um_accelshark_psg_writer #(
  parameter int unsigned GAP_CYCLES = 1,  // 0..15
  parameter int unsigned ADDR_CACHE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       req_valid,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       strobe,
  output logic       address,
  output logic       data_high,
  output logic [3:0] da,
  output logic       done
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StDlo,
    StDhi,
    StCommit,
    StGap
  } state_e;

  // Gap counter is loaded with the count of gap cycles still to follow the first one.
  localparam logic [3:0] GapLast = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  state_e     nxt_q, nxt_d;  // strobe state to enter once the gap expires
  logic [3:0] gap_q, gap_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [3:0] cache_addr_q, cache_addr_d;
  logic       cache_vld_q, cache_vld_d;
  logic       strobe_q, strobe_d;
  logic       address_q, address_d;
  logic       data_high_q, data_high_d;
  logic [3:0] da_q, da_d;
  logic       done_q, done_d;

  logic       cache_hit;
  logic       step;
  state_e     step_st;
  logic       launch;
  state_e     launch_st;

  assign cache_hit = (ADDR_CACHE != 0) && cache_vld_q && (req_addr == cache_addr_q);

  // Next-state: sequence the strobes, insert gaps, and preload the outputs of
  // the strobe being launched so they are registered.
  always_comb begin
    state_d      = state_q;
    nxt_d        = nxt_q;
    gap_d        = gap_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cache_addr_d = cache_addr_q;
    cache_vld_d  = cache_vld_q;
    strobe_d     = strobe_q;
    address_d    = address_q;
    data_high_d  = data_high_q;
    da_d         = da_q;
    done_d       = done_q;
    step         = 1'b0;
    step_st      = StIdle;
    launch       = 1'b0;
    launch_st    = StIdle;

    // With ena low nothing moves; the held strobe/done are masked at the ports
    // so a paused strobe is re-issued for a full cycle when ena returns.
    if (ena) begin
      strobe_d = 1'b0;
      done_d   = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_d    = req_addr;
            data_d    = req_data;
            launch    = 1'b1;
            launch_st = cache_hit ? StDlo : StAddr;
          end
        end
        StAddr: begin
          cache_addr_d = addr_q;
          cache_vld_d  = 1'b1;
          step         = 1'b1;
          step_st      = StDlo;
        end
        StDlo: begin
          step    = 1'b1;
          step_st = StDhi;
        end
        StDhi: begin
          step    = 1'b1;
          step_st = StCommit;
        end
        StCommit: begin
          done_d  = 1'b1;
          step    = 1'b1;
          step_st = StIdle;
        end
        StGap: begin
          if (gap_q == 4'd0) begin
            state_d   = nxt_q;
            launch    = (nxt_q != StIdle);
            launch_st = nxt_q;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (step) begin
        if (GAP_CYCLES == 0) begin
          state_d   = step_st;
          launch    = (step_st != StIdle);
          launch_st = step_st;
        end else begin
          state_d = StGap;
          nxt_d   = step_st;
          gap_d   = GapLast;
        end
      end

      if (launch) begin
        state_d  = launch_st;
        strobe_d = 1'b1;
        unique case (launch_st)
          StAddr: begin
            address_d   = 1'b1;
            data_high_d = 1'b0;
            da_d        = addr_d;
          end
          StDlo: begin
            address_d   = 1'b0;
            data_high_d = 1'b0;
            da_d        = data_d[3:0];
          end
          StDhi, StCommit: begin
            address_d   = 1'b0;
            data_high_d = 1'b1;
            da_d        = data_d[7:4];
          end
          default: strobe_d = 1'b0;
        endcase
      end
    end
  end

  // State register; reset abandons any write in flight and drops the cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      nxt_q        <= StIdle;
      gap_q        <= 4'd0;
      addr_q       <= 4'd0;
      data_q       <= 8'd0;
      cache_addr_q <= 4'd0;
      cache_vld_q  <= 1'b0;
      strobe_q     <= 1'b0;
      address_q    <= 1'b0;
      data_high_q  <= 1'b0;
      da_q         <= 4'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      nxt_q        <= nxt_d;
      gap_q        <= gap_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cache_addr_q <= cache_addr_d;
      cache_vld_q  <= cache_vld_d;
      strobe_q     <= strobe_d;
      address_q    <= address_d;
      data_high_q  <= data_high_d;
      da_q         <= da_d;
      done_q       <= done_d;
    end
  end

  assign req_ready = ena && (state_q == StIdle);
  assign strobe    = strobe_q && ena;
  assign done      = done_q && ena;
  assign address   = address_q;
  assign data_high = data_high_q;
  assign da        = da_q;

endmodule

// File: tb/tb_tt_um_accelshark_psg_writer.sv
// Directed bench: two writers (gap 0 and gap 1) share the request bus; only the
// one selected by sel has ena high. A small PSG receiver model per writer
// assembles nybbles into registers and logs every strobe with its cycle.
module tb_tt_um_accelshark_psg_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena0, ena1, req_valid, sel;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic       rdy0, strobe0, address0, dh0, done0;
  logic       rdy1, strobe1, address1, dh1, done1;
  logic [3:0] da0, da1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       req_ready, strobe, address, dh, done;
  logic [3:0] da;
  assign req_ready = sel ? rdy1 : rdy0;
  assign strobe    = sel ? strobe1 : strobe0;
  assign address   = sel ? address1 : address0;
  assign dh        = sel ? dh1 : dh0;
  assign done      = sel ? done1 : done0;
  assign da        = sel ? da1 : da0;

  tt_um_accelshark_psg_writer #(.GAP_CYCLES(0), .ADDR_CACHE(1)) u_dut_g0 (
    .clk(clk), .rst_n(rst_n), .ena(ena0), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(rdy0), .strobe(strobe0), .address(address0),
    .data_high(dh0), .da(da0), .done(done0)
  );

  tt_um_accelshark_psg_writer #(.GAP_CYCLES(1), .ADDR_CACHE(1)) u_dut_g1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(rdy1), .strobe(strobe1), .address(address1),
    .data_high(dh1), .da(da1), .done(done1)
  );

  // Receiver models: address nybble selects register, repeated high strobe commits.
  int         lc0[$], lc1[$];
  logic [5:0] lv0[$], lv1[$];
  logic [7:0] regs0 [16] = '{default: 8'h00};
  logic [7:0] regs1 [16] = '{default: 8'h00};
  logic [3:0] ra0 = '0, lo0 = '0, hi0 = '0, ra1 = '0, lo1 = '0, hi1 = '0;
  logic       ldh0 = 1'b0, ldh1 = 1'b0;
  int         dn0 = 0, dc0 = 0, dn1 = 0, dc1 = 0;

  always @(negedge clk) begin
    if (strobe0) begin
      lc0.push_back(cyc);
      lv0.push_back({address0, dh0, da0});
      if (address0) begin ra0 <= da0; ldh0 <= 1'b0; end
      else if (!dh0) begin lo0 <= da0; ldh0 <= 1'b0; end
      else if (ldh0) begin regs0[ra0] <= {hi0, lo0}; ldh0 <= 1'b0; end
      else begin hi0 <= da0; ldh0 <= 1'b1; end
    end
    if (done0) begin dn0 <= dn0 + 1; dc0 <= cyc; end
  end

  always @(negedge clk) begin
    if (strobe1) begin
      lc1.push_back(cyc);
      lv1.push_back({address1, dh1, da1});
      if (address1) begin ra1 <= da1; ldh1 <= 1'b0; end
      else if (!dh1) begin lo1 <= da1; ldh1 <= 1'b0; end
      else if (ldh1) begin regs1[ra1] <= {hi1, lo1}; ldh1 <= 1'b0; end
      else begin hi1 <= da1; ldh1 <= 1'b1; end
    end
    if (done1) begin dn1 <= dn1 + 1; dc1 <= cyc; end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_strobe(input string tag, input int idx, input int ecyc, input logic [5:0] ev);
    int         c;
    logic [5:0] v;
    c = -1;
    v = 6'h3f;
    if (sel) begin
      if (idx < lc1.size()) begin c = lc1[idx]; v = lv1[idx]; end
    end else begin
      if (idx < lc0.size()) begin c = lc0[idx]; v = lv0[idx]; end
    end
    check_eq({tag, "_cyc"}, 32'(c), 32'(ecyc));
    check_eq({tag, "_val"}, 32'(v), 32'(ev));
  endtask

  function automatic int log_size();
    return sel ? lc1.size() : lc0.size();
  endfunction

  // Present a request and return the number of the edge that accepted it.
  task automatic send(input logic [3:0] a, input logic [7:0] d, output int hs);
    int n;
    n = 0;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) check_eq("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    hs        = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(output int rc);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) check_eq("ready_timeout", 32'd0, 32'd1);
    rc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, hs2, rc, base, dbase, rel;
    rst_n     = 1'b0;
    ena0      = 1'b0;
    ena1      = 1'b1;
    sel       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 4'h0;
    req_data  = 8'h00;
    #2;
    check_eq("rst_outs", 32'({strobe, address, dh, da, done}), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Gap 1, cache miss: 4 strobes spaced by one idle cycle.
    base  = log_size();
    dbase = dn1;
    send(4'h2, 8'hA5, hs);
    wait_ready(rc);
    check_eq("a_count", 32'(log_size() - base), 32'd4);
    chk_strobe("a_s0", base + 0, hs + 0, {1'b1, 1'b0, 4'h2});
    chk_strobe("a_s1", base + 1, hs + 2, {1'b0, 1'b0, 4'h5});
    chk_strobe("a_s2", base + 2, hs + 4, {1'b0, 1'b1, 4'hA});
    chk_strobe("a_s3", base + 3, hs + 6, {1'b0, 1'b1, 4'hA});
    check_eq("a_ready", 32'(rc - hs), 32'd8);
    check_eq("a_done_n", 32'(dn1 - dbase), 32'd1);
    check_eq("a_done_cyc", 32'(dc1), 32'(hs + 7));
    check_eq("a_pitch", 32'(regs1[2]), 32'hA5);

    // Same address: cache hit, 3 strobes.
    base = log_size();
    send(4'h2, 8'h3C, hs);
    wait_ready(rc);
    check_eq("b_count", 32'(log_size() - base), 32'd3);
    chk_strobe("b_s0", base + 0, hs + 0, {1'b0, 1'b0, 4'hC});
    chk_strobe("b_s1", base + 1, hs + 2, {1'b0, 1'b1, 4'h3});
    chk_strobe("b_s2", base + 2, hs + 4, {1'b0, 1'b1, 4'h3});
    check_eq("b_ready", 32'(rc - hs), 32'd6);
    check_eq("b_pitch", 32'(regs1[2]), 32'h3C);

    // Request bus keeps changing while busy; only latched values go out.
    base = log_size();
    send(4'h5, 8'h11, hs);
    req_valid = 1'b1;
    req_addr  = 4'h6;
    req_data  = 8'h22;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("f_busy_rdy", 32'(req_ready), 32'd0);
      req_data = req_data + 8'h11;
    end
    req_valid = 1'b0;
    wait_ready(rc);
    check_eq("f_count", 32'(log_size() - base), 32'd4);
    chk_strobe("f_s0", base + 0, hs + 0, {1'b1, 1'b0, 4'h5});
    chk_strobe("f_s1", base + 1, hs + 2, {1'b0, 1'b0, 4'h1});
    chk_strobe("f_s3", base + 3, hs + 6, {1'b0, 1'b1, 4'h1});
    check_eq("f_reg5", 32'(regs1[5]), 32'h11);
    check_eq("f_reg6", 32'(regs1[6]), 32'h00);

    // ena dropped for 3 cycles during DHI: DHI re-issued in full afterwards.
    base = log_size();
    send(4'h9, 8'hB4, hs);
    repeat (4) @(posedge clk);
    #1;
    ena1 = 1'b0;
    #1;
    check_eq("d_stall_strobe", 32'(strobe), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    ena1 = 1'b1;
    wait_ready(rc);
    check_eq("d_count", 32'(log_size() - base), 32'd4);
    chk_strobe("d_s1", base + 1, hs + 2, {1'b0, 1'b0, 4'h4});
    chk_strobe("d_s2", base + 2, hs + 7, {1'b0, 1'b1, 4'hB});
    chk_strobe("d_s3", base + 3, hs + 9, {1'b0, 1'b1, 4'hB});
    check_eq("d_ready", 32'(rc - hs), 32'd11);
    check_eq("d_reg9", 32'(regs1[9]), 32'hB4);

    // Reset during DLO (cache hit on 9): outputs clear at once, cache dropped.
    send(4'h9, 8'h77, hs);
    check_eq("e_dlo_up", 32'({strobe, address, dh, da}), 32'({1'b1, 1'b0, 1'b0, 4'h7}));
    rst_n = 1'b0;
    #1;
    check_eq("e_rst_outs", 32'({strobe, address, dh, da, done}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel   = cyc;
    base  = log_size();
    send(4'h9, 8'h66, hs);
    check_eq("e_first_accept", 32'(hs - rel), 32'd1);
    wait_ready(rc);
    check_eq("e_count", 32'(log_size() - base), 32'd4);
    chk_strobe("e_s0", base + 0, hs + 0, {1'b1, 1'b0, 4'h9});
    check_eq("e_reg9", 32'(regs1[9]), 32'h66);

    // Gap 0: back-to-back strobes, writes to 0 then 7.
    ena1 = 1'b0;
    ena0 = 1'b1;
    sel  = 1'b0;
    @(posedge clk);
    #1;
    base  = log_size();
    dbase = dn0;
    send(4'h0, 8'h5A, hs);
    wait_ready(rc);
    check_eq("c_ready", 32'(rc - hs), 32'd4);
    chk_strobe("c_s0", base + 0, hs + 0, {1'b1, 1'b0, 4'h0});
    chk_strobe("c_s1", base + 1, hs + 1, {1'b0, 1'b0, 4'hA});
    chk_strobe("c_s2", base + 2, hs + 2, {1'b0, 1'b1, 4'h5});
    chk_strobe("c_s3", base + 3, hs + 3, {1'b0, 1'b1, 4'h5});
    send(4'h7, 8'hC3, hs2);
    wait_ready(rc);
    check_eq("c2_count", 32'(log_size() - base), 32'd8);
    chk_strobe("c2_s0", base + 4, hs2 + 0, {1'b1, 1'b0, 4'h7});
    chk_strobe("c2_s1", base + 5, hs2 + 1, {1'b0, 1'b0, 4'h3});
    chk_strobe("c2_s3", base + 7, hs2 + 3, {1'b0, 1'b1, 4'hC});
    repeat (2) @(posedge clk);
    #1;
    check_eq("c_done_n", 32'(dn0 - dbase), 32'd2);
    check_eq("c_done_cyc", 32'(dc0), 32'(hs2 + 4));
    check_eq("c_enable", 32'(regs0[0]), 32'h5A);
    check_eq("c_vol23", 32'(regs0[7]), 32'hC3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
